// File: rtl/fwdcombine_n.sv
// fwdcombine_n: N-channel packet combiner feeding one forwarder.
// MODE 0 forwards in strict round-robin order; MODE 1 picks the lowest ready index.
module fwdcombine_n #(
    parameter int N_CHAN     = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9,
    parameter int PLEN_WIDTH = ADDR_WIDTH + 1,
    parameter int MODE       = 0,
    parameter int SEL_WIDTH  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [ADDR_WIDTH-1:0]        up_rd_addr,
    input  logic [N_CHAN*DATA_WIDTH-1:0] up_rd_data,
    output logic [N_CHAN-1:0]            up_rd_en,
    output logic [N_CHAN-1:0]            up_done,
    input  logic [N_CHAN-1:0]            up_ready,
    input  logic [N_CHAN*PLEN_WIDTH-1:0] up_len,
    input  logic [ADDR_WIDTH-1:0]        forwarder_rd_addr,
    output logic [DATA_WIDTH-1:0]        forwarder_rd_data,
    input  logic                         forwarder_rd_en,
    input  logic                         forwarder_done,
    output logic                         ready_for_forwarder,
    output logic [PLEN_WIDTH-1:0]        len_to_forwarder,
    output logic [31:0]                  pkt_count,
    output logic [SEL_WIDTH-1:0]         cur_sel,
    output logic                         err_done,
    output logic                         err_ready_drop
);
    typedef enum logic [1:0] {IDLE, LOCKED, GAP} state_t;

    state_t                r_state;
    logic [SEL_WIDTH-1:0]  r_ptr;
    logic [SEL_WIDTH-1:0]  r_sel;
    logic [31:0]           r_cnt;
    logic                  r_err_done;
    logic                  r_err_drop;

    logic                  w_lock;
    logic                  w_sel_ready;
    logic                  w_grant;
    logic [SEL_WIDTH-1:0]  w_low;
    logic [SEL_WIDTH-1:0]  w_next_sel;
    logic [SEL_WIDTH-1:0]  w_next_ptr;
    logic [N_CHAN-1:0]     w_onehot;

    always_comb begin
        w_low = '0;
        for (int i = N_CHAN - 1; i >= 0; i--)
            if (up_ready[i]) w_low = SEL_WIDTH'(i);
    end

    assign w_lock      = (r_state == LOCKED) && !rst;
    assign w_sel_ready = up_ready[r_sel];
    assign w_grant     = (MODE == 0) ? up_ready[r_ptr] : |up_ready;
    assign w_next_sel  = (MODE == 0) ? r_ptr : w_low;
    assign w_next_ptr  = (r_sel == SEL_WIDTH'(N_CHAN - 1)) ? '0 : r_sel + 1'b1;
    assign w_onehot    = N_CHAN'(1) << r_sel;

    assign up_rd_addr          = forwarder_rd_addr;
    assign up_rd_en            = (w_lock && forwarder_rd_en) ? w_onehot : '0;
    assign up_done             = (w_lock && forwarder_done) ? w_onehot : '0;
    assign ready_for_forwarder = w_lock && w_sel_ready;
    assign len_to_forwarder    = up_len[r_sel*PLEN_WIDTH +: PLEN_WIDTH];
    // sel persists past the packet so late read data is still routed to the forwarder
    assign forwarder_rd_data   = up_rd_data[r_sel*DATA_WIDTH +: DATA_WIDTH];
    assign pkt_count           = r_cnt;
    assign cur_sel             = r_sel;
    assign err_done            = r_err_done;
    assign err_ready_drop      = r_err_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_sel      <= '0;
            r_cnt      <= '0;
            r_err_done <= 1'b0;
            r_err_drop <= 1'b0;
        end else begin
            if (forwarder_done && r_state != LOCKED) r_err_done <= 1'b1;
            case (r_state)
                IDLE: if (w_grant) begin
                    r_sel   <= w_next_sel;
                    r_state <= LOCKED;
                end
                LOCKED: if (forwarder_done) begin
                    r_cnt   <= r_cnt + 32'd1;
                    r_state <= GAP;
                    if (MODE == 0) r_ptr <= w_next_ptr;
                end else if (!w_sel_ready) begin
                    r_err_drop <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
